// File: rtl/lsb_first_serializer.sv
// LSB-first parallel-to-serial front end: one-word hold buffer feeding a
// WIDTH-bit shift register, with frame_start/frame_last markers per word.
module lsb_first_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_last,
  output logic             busy
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             at_last;

  // Handshake: a word transfers at a rising edge where din_valid & din_ready;
  // din_ready depends only on hold_full, never on din_valid, and din/din_valid
  // are ignored while din_ready is low.
  assign accept  = din_valid & ~hold_full;
  assign at_last = (state == SHIFT) && (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      hold      <= '0;
      hold_full <= 1'b0;
      sr        <= '0;
      cnt       <= '0;
    end else begin
      if (accept) begin
        hold <= din;
      end
      case (state)
        IDLE: begin
          if (hold_full) begin
            sr        <= hold;
            cnt       <= '0;
            hold_full <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (!at_last) begin
            sr  <= sr >> 1;
            cnt <= cnt + CW'(1);
          end else if (hold_full) begin
            // next word follows with no idle gap
            sr        <= hold;
            cnt       <= '0;
            hold_full <= 1'b0;
          end else begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
      // an accept on the same edge as a load refills the buffer
      if (accept) begin
        hold_full <= 1'b1;
      end
    end
  end

  assign ser_out     = sr[0];
  assign ser_valid   = (state == SHIFT);
  assign frame_start = (state == SHIFT) && (cnt == '0);
  assign frame_last  = at_last;
  assign din_ready   = ~hold_full;
  assign busy        = (state == SHIFT) | hold_full;

endmodule

// File: tb/tb_lsb_first_serializer.sv
// Bench for lsb_first_serializer: randomized traffic on an 8-bit instance
// checked against a frame-schedule model, plus directed 5-bit literal frames.
module tb_lsb_first_serializer;

  localparam int W  = 8;
  localparam int W5 = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic reset5;

  // ---------------- DUT (WIDTH=8) ----------------
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready, ser_out, ser_valid, frame_start, frame_last, busy;

  lsb_first_serializer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .ser_out(ser_out), .ser_valid(ser_valid),
    .frame_start(frame_start), .frame_last(frame_last), .busy(busy)
  );

  // ---------------- DUT (WIDTH=5) ----------------
  logic [W5-1:0] din5;
  logic          din_valid5;
  logic          din_ready5, ser_out5, ser_valid5, frame_start5, frame_last5, busy5;

  lsb_first_serializer #(.WIDTH(W5)) dut5 (
    .clk(clk), .reset(reset5), .din(din5), .din_valid(din_valid5),
    .din_ready(din_ready5), .ser_out(ser_out5), .ser_valid(ser_valid5),
    .frame_start(frame_start5), .frame_last(frame_last5), .busy(busy5)
  );

  // ---------------- scoreboard state ----------------
  int pass_cnt  = 0;
  int check_cnt = 0;
  bit done5     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (time %0t)", name, act, exp, $time);
  endtask

  // Model: each accepted word becomes a frame occupying the cycles after
  // edges fs..fs+W-1; it waits in the hold buffer from its accept edge until fs.
  int               t = 0;
  logic [W-1:0]     fw[$];
  int               fs[$];
  int               fn[$];
  logic [W-1:0]     exp_q[$];
  logic [W-1:0]     acc;

  function automatic bit m_hold_full(input int tt);
    foreach (fn[i]) if (fn[i] <= tt && tt < fs[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_frame(input int tt);
    foreach (fs[i]) if (tt >= fs[i] && tt <= fs[i] + W - 1) return i;
    return -1;
  endfunction

  task automatic model_clear();
    fw.delete(); fs.delete(); fn.delete(); exp_q.delete();
  endtask

  task automatic compare8(input int tt);
    int   f;
    logic e_valid, e_out, e_fs, e_fl, e_rdy, e_busy;
    logic [W-1:0] e_word;
    f = -1;
    e_valid = 1'b0; e_out = 1'b0; e_fs = 1'b0; e_fl = 1'b0; e_rdy = 1'b1; e_busy = 1'b0;
    if (reset) begin
      f       = m_frame(tt);
      e_valid = (f >= 0);
      if (e_valid) begin
        e_out = fw[f][tt - fs[f]];
        e_fs  = (tt == fs[f]);
        e_fl  = (tt == fs[f] + W - 1);
      end
      e_rdy  = !m_hold_full(tt);
      e_busy = e_valid || !e_rdy;
    end
    check("ser_valid", ser_valid, e_valid);
    check("frame_start", frame_start, e_fs);
    check("frame_last", frame_last, e_fl);
    check("din_ready", din_ready, e_rdy);
    check("busy", busy, e_busy);
    if (!reset || e_valid) check("ser_out", ser_out, e_out);
    if (e_valid) begin
      acc[tt - fs[f]] = ser_out;
      if (e_fl && exp_q.size() > 0) begin
        e_word = exp_q.pop_front();
        check("frame_word", acc, e_word);
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic [W-1:0] d);
    int s;
    din_valid = v;
    din       = d;
    @(posedge clk);
    t++;
    if (reset && din_valid && !m_hold_full(t - 1)) begin
      s = t + 1;
      if (fs.size() > 0 && fs[$] + W > s) s = fs[$] + W;
      fw.push_back(din);
      fs.push_back(s);
      fn.push_back(t);
      exp_q.push_back(din);
    end
    @(negedge clk);
    compare8(t);
  endtask

  bit a5_seq [8] = '{1, 0, 1, 0, 0, 1, 0, 1};

  // ---------------- main sequence (WIDTH=8) ----------------
  initial begin : main
    reset     = 1'b0;
    din_valid = 1'b1;
    din       = 8'h3C;
    #1;
    compare8(t);
    // reset held with din_valid high: nothing may be accepted
    repeat (2) step(1'b1, 8'($urandom));
    reset = 1'b1;
    repeat (3) step(1'b0, 8'($urandom));

    // single frame, then a short burst
    step(1'b1, 8'h6B);
    repeat (W + 2) step(1'b0, 8'h00);
    repeat (4) step(1'b1, 8'($urandom));
    repeat (2 * W + 2) step(1'b0, 8'h00);

    // random traffic, then a sustained stall with din changing every cycle
    repeat (200) step(1'($urandom_range(0, 3) != 0), 8'($urandom));
    repeat (40) step(1'b1, 8'($urandom));
    repeat (2 * W + 2) step(1'b0, 8'h00);

    // reset mid-frame after bit 2 with a word held
    step(1'b1, 8'hC3);
    step(1'b1, 8'h99);
    step(1'b1, 8'h99);
    step(1'b0, 8'h00);
    check("pre_reset_held", din_ready, 1'b0);
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    compare8(t);
    step(1'b1, 8'($urandom));
    reset = 1'b1;

    // 8'hA5 after reset: literal bit sequence
    step(1'b1, 8'hA5);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 8'h00);
      check("a5_bit", ser_out, a5_seq[k]);
      check("a5_start", frame_start, (k == 0));
    end
    step(1'b0, 8'h00);
    check("a5_done", ser_valid, 1'b0);

    // late arrival: accept exactly at the last-bit edge with hold empty
    step(1'b1, 8'h5A);
    repeat (W) step(1'b0, 8'h00);
    check("late_last", frame_last, 1'b1);
    step(1'b1, 8'hE7);
    check("late_gap", ser_valid, 1'b0);
    step(1'b0, 8'h00);
    check("late_start", frame_start, 1'b1);
    repeat (W + 2) step(1'b0, 8'h00);

    check("w5_sequence_done", done5, 1'b1);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  // ---------------- directed WIDTH=5 frames ----------------
  bit s2 [5]  = '{0, 1, 1, 0, 1};
  bit s3 [10] = '{0, 1, 1, 0, 1, 1, 1, 0, 1, 0};

  initial begin : p5
    reset5     = 1'b0;
    din5       = '0;
    din_valid5 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset5 = 1'b1;
    @(negedge clk);

    // single frame 5'b10110
    din5       = 5'b10110;
    din_valid5 = 1'b1;
    @(negedge clk);
    din_valid5 = 1'b0;
    check("w5_latency", ser_valid5, 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k < 5) begin
        check("w5_single_bit", ser_out5, s2[k]);
        check("w5_single_valid", ser_valid5, 1'b1);
        check("w5_single_start", frame_start5, (k == 0));
        check("w5_single_last", frame_last5, (k == 4));
      end else begin
        check("w5_single_end", ser_valid5, 1'b0);
      end
    end

    // back-to-back frames with din_valid held high
    din5       = 5'b10110;
    din_valid5 = 1'b1;
    @(negedge clk);
    din5 = 5'b01011;
    check("w5_b2b_ready", din_ready5, 1'b0);
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      if (k < 10) begin
        check("w5_b2b_bit", ser_out5, s3[k]);
        check("w5_b2b_valid", ser_valid5, 1'b1);
        check("w5_b2b_start", frame_start5, (k == 0 || k == 5));
        check("w5_b2b_last", frame_last5, (k == 4 || k == 9));
      end else begin
        check("w5_b2b_end", ser_valid5, 1'b0);
      end
      if (k == 1) begin
        check("w5_b2b_held", din_ready5, 1'b0);
        din_valid5 = 1'b0;
      end
    end
    check("w5_idle_busy", busy5, 1'b0);
    done5 = 1'b1;
  end

endmodule

// File: doc/lsb_first_serializer.md
Name: lsb_first_serializer

Overview:
- Parallel-to-serial front end for the bit-serial 2's complement FSM.
- Accepts WIDTH-bit words through a valid/ready handshake and buffers one word.
- Shifts each word out LSB first, one bit per clock.
- Emits per-frame markers. frame_start is used to clear the downstream FSM before bit 0.

Parameters:
- WIDTH, 8, data word width in bits. Legal range is WIDTH >= 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  din is valid this cycle.
- din_ready  output  1  hold buffer is empty; a word is accepted when din_valid & din_ready at a rising edge.
- ser_out  output  1  current serial bit, LSB first.
- ser_valid  output  1  ser_out carries a frame bit this cycle.
- frame_start  output  1  high during bit 0 of every frame.
- frame_last  output  1  high during bit WIDTH-1 of every frame.
- busy  output  1  a frame is shifting or a word is held.

Behaviour:
- State:
  - FSM states: IDLE, SHIFT.
  - One-word hold register plus a hold_full flag.
  - WIDTH-bit shift register sr.
  - Bit counter cnt, $clog2(WIDTH) bits, range 0..WIDTH-1.
- Reset (reset=0, takes effect immediately, asynchronously):
  - state=IDLE, hold_full=0, sr=0, cnt=0.
  - Outputs: ser_out=0, ser_valid=0, frame_start=0, frame_last=0, busy=0, din_ready=1.
  - A held word and any partial frame are discarded.
- Output decode (from registers only; no combinational path from din/din_valid to any output):
  - ser_out = sr[0].
  - ser_valid = (state==SHIFT).
  - frame_start = SHIFT & cnt==0.
  - frame_last = SHIFT & cnt==WIDTH-1.
  - din_ready = ~hold_full.
  - busy = SHIFT | hold_full.
- Accept: on an edge with din_valid & din_ready, hold<=din and hold_full<=1. While din_ready=0, din and din_valid are ignored.
- IDLE: at an edge with hold_full=1: sr<=hold, cnt<=0, hold_full<=0, state<=SHIFT.
- SHIFT, cnt<WIDTH-1: sr<=sr>>1 (zero fill), cnt<=cnt+1.
- SHIFT, cnt==WIDTH-1:
  - If hold_full=1: sr<=hold, cnt<=0, hold_full<=0, stay in SHIFT. This gives gapless back-to-back frames.
  - Otherwise: state<=IDLE, cnt<=0.
- Latency: a word accepted at edge N into an idle block gives bit 0 on ser_out in the cycle after edge N+1. Bit k appears in the cycle after edge N+1+k.
- Simultaneous accept and load (same edge): the load empties hold_full and the accept refills it. The new word is captured and not lost, and din_ready stays 0.
- Word accepted at the same edge as the last-bit transition to IDLE: exactly one cycle with ser_valid=0, then the new frame starts.
- Throughput: sustained one bit per cycle. A new word can be accepted while the current frame shifts.

Test Plan:
1. Reset
   - Stimulus: hold reset=0 for 2 cycles with din_valid=1.
   - Required response: all outputs 0 except din_ready=1; nothing is accepted; ser_valid stays 0 after release until a word is accepted.
2. Single frame
   - Stimulus: WIDTH=5, din=5'b10110 accepted at edge N.
   - Required response: ser_out=0,1,1,0,1 in cycles after edges N+1..N+5. frame_start in the first of those cycles, frame_last in the fifth, ser_valid high for exactly 5 cycles.
   - Chained to the 2's complement FSM (frame_start driving its clear), the FSM emits 0,1,0,1,0.
3. Back-to-back frames
   - Stimulus: WIDTH=5, words 5'b10110 then 5'b01011 with din_valid held high.
   - Required response: the second word is accepted during the first frame. ser_valid is continuous for 10 cycles, and frame_start is asserted in the cycle immediately after frame_last.
   - Bit stream: 0,1,1,0,1,1,1,0,1,0.
4. Stall
   - Stimulus: keep hold full while a frame shifts, and change din every cycle with din_valid=1.
   - Required response: din_ready=0 throughout, and the serialized bits match only the accepted words.
5. Reset mid-frame
   - Stimulus: assert reset=0 between clock edges after bit 2 of a frame, with a word also held.
   - Required response: outputs clear immediately without waiting for a clock edge.
   - After release, a new word 8'hA5 (WIDTH=8) serializes from bit 0 as 1,0,1,0,0,1,0,1 with frame_start on the first bit.
6. Late arrival
   - Stimulus: accept a word exactly at the last-bit edge with hold empty.
   - Required response: one cycle with ser_valid=0, then the new frame with frame_start=1.
